// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an oversampling strobe; glitched starts are dropped,
// bad stop bits pulse frame_err_o, and bytes not yet acknowledged pulse overrun_o.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_en_i,
  input  logic                 rx_i,
  input  logic                 data_ack_i,
  output logic [DATA_BITS-1:0] data_out_o,
  output logic                 data_valid_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS:0]   shift_ext;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick_mid, tick_last, stop_tick;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign tick_mid  = (tick_q == TICK_MID);
  assign tick_last = (tick_q == TICK_LAST);
  assign stop_tick = rx_en_i && (state_q == S_STOP) && tick_last;
  assign shift_ext = {rx_s_q, shift_q};

  always_comb begin
    state_d = state_q;
    if (rx_en_i) begin
      case (state_q)
        S_IDLE:  if (!rx_s_q) state_d = S_START;
        S_START: if (tick_mid) state_d = rx_s_q ? S_IDLE : S_DATA;
        S_DATA:  if (tick_last && (bit_q == BIT_LAST)) state_d = S_STOP;
        S_STOP:  if (tick_last) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  always_comb begin
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (rx_en_i) begin
      case (state_q)
        S_IDLE: begin
          tick_d = '0;
          bit_d  = '0;
        end
        S_START: begin
          if (tick_mid) begin
            tick_d = '0;
            bit_d  = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_last) begin
            tick_d  = '0;
            shift_d = shift_ext[DATA_BITS:1];
            bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          tick_d = tick_last ? '0 : tick_q + 1'b1;
          bit_d  = '0;
        end
      endcase
    end
    if (valid_q && data_ack_i) valid_d = 1'b0;
    // A load in the ack cycle wins and is not an overrun.
    if (stop_tick) begin
      if (rx_s_q) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ovr_d   = valid_q && !data_ack_i;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven tick-aligned on the serial line and
// outputs are checked at #1 after the relevant clock edges.
module tb_uart_rx;

  localparam int TP = 16;  // clk cycles per rx_en tick

  logic       clk;
  logic       rst;
  logic       rx_en;
  logic       rx;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int errs    = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_en_i      (rx_en),
    .rx_i         (rx),
    .data_ack_i   (data_ack),
    .data_out_o   (data_out),
    .data_valid_o (data_valid),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .busy_o       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rx_en = 1'b0;
    forever begin
      repeat (TP - 1) @(negedge clk);
      rx_en = 1'b1;
      @(negedge clk);
      rx_en = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!rx_en && n < 4 * TP);
    if (!rx_en) begin
      vectors++;
      errs++;
      $display("FAIL tick_timeout: observed no rx_en within %0d cycles", 4 * TP);
    end
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) wait_tick();
  endtask

  // Starts at #1 after a tick; returns at #1 after the stop-sample tick.
  task automatic send_frame(input logic [7:0] d, input logic stopv, input logic ack_at_stop,
                            output logic pre_valid, output logic pre_busy);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stopv;
    wait_ticks(8);
    repeat (TP - 1) @(posedge clk);
    #1;
    pre_valid = data_valid;
    pre_busy  = busy;
    data_ack  = ack_at_stop;
    @(posedge clk);
    #1;
    data_ack = 1'b0;
    rx = 1'b1;
  endtask

  task automatic ack_byte();
    data_ack = 1'b1;
    @(posedge clk);
    #1;
    data_ack = 1'b0;
  endtask

  initial begin
    logic       pv, pb;
    logic [4:0] acc;
    int         f0;

    rst = 1'b1;
    rx = 1'b1;
    data_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);

    acc = '0;
    for (int k = 0; k < 200; k++) begin
      wait_tick();
      acc = acc | {data_out != 8'h00, data_valid, frame_err, overrun, busy};
    end
    check("idle_outputs", acc, 5'b0);
    check("idle_ferr_cnt", ferr_cnt, 0);

    send_frame(8'hA5, 1'b1, 1'b0, pv, pb);
    check("a5_pre_valid", pv, 1'b0);
    check("a5_pre_busy", pb, 1'b1);
    check("a5_valid", data_valid, 1'b1);
    check("a5_data", data_out, 8'hA5);
    check("a5_busy_fall", busy, 1'b0);
    check("a5_no_ferr", frame_err, 1'b0);
    ack_byte();
    check("a5_ack_clears", data_valid, 1'b0);
    check("a5_data_kept", data_out, 8'hA5);
    wait_ticks(7);

    rx = 1'b0;
    wait_tick();
    check("glitch_busy_rise", busy, 1'b1);
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(4);
    check("glitch_busy_t8", busy, 1'b1);
    wait_tick();
    check("glitch_busy_t9", busy, 1'b0);
    wait_ticks(20);
    check("glitch_no_valid", data_valid, 1'b0);
    check("glitch_no_ferr", ferr_cnt, 0);

    send_frame(8'h3C, 1'b0, 1'b0, pv, pb);
    check("fe_pulse", frame_err, 1'b1);
    check("fe_valid", data_valid, 1'b0);
    check("fe_data_kept", data_out, 8'hA5);
    @(posedge clk);
    #1;
    check("fe_pulse_width", frame_err, 1'b0);
    wait_ticks(7);
    check("fe_count", ferr_cnt, 1);

    send_frame(8'h11, 1'b1, 1'b0, pv, pb);
    check("b11_data", data_out, 8'h11);
    check("b11_no_ovr", overrun, 1'b0);
    wait_ticks(7);
    send_frame(8'h22, 1'b1, 1'b0, pv, pb);
    check("ovr_pre_valid", pv, 1'b1);
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_data", data_out, 8'h22);
    check("ovr_valid", data_valid, 1'b1);
    @(posedge clk);
    #1;
    check("ovr_pulse_width", overrun, 1'b0);
    wait_ticks(7);
    send_frame(8'h33, 1'b1, 1'b1, pv, pb);
    check("race_no_ovr", overrun, 1'b0);
    check("race_valid", data_valid, 1'b1);
    check("race_data", data_out, 8'h33);
    check("ovr_count", ovr_cnt, 1);
    ack_byte();
    check("race_ack_clears", data_valid, 1'b0);
    wait_ticks(7);

    send_frame(8'h00, 1'b1, 1'b0, pv, pb);
    check("b2b_00_data", data_out, 8'h00);
    check("b2b_00_valid", data_valid, 1'b1);
    ack_byte();
    wait_ticks(7);
    send_frame(8'hFF, 1'b1, 1'b0, pv, pb);
    check("b2b_ff_data", data_out, 8'hFF);
    check("b2b_ff_valid", data_valid, 1'b1);
    check("b2b_no_ovr", ovr_cnt, 1);
    check("b2b_no_ferr", ferr_cnt, 1);
    ack_byte();
    wait_ticks(7);

    rx = 1'b0;
    wait_ticks(72);
    check("mid_busy", busy, 1'b1);
    rx = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", data_valid, 1'b0);
    check("midrst_data", data_out, 8'h00);
    wait_ticks(200);
    check("midrst_no_ferr", ferr_cnt, 1);
    check("midrst_no_ovr", ovr_cnt, 1);
    check("midrst_idle", busy, 1'b0);

    f0 = ferr_cnt;
    rx = 1'b0;
    wait_ticks(310);
    rx = 1'b1;
    wait_ticks(20);
    check("break_ferr_repeats", ferr_cnt - f0, 2);
    check("break_no_valid", data_valid, 1'b0);
    check("break_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
